// File: rtl/wxyz_sequencer_if.sv
// Bundle of sweep controls and converter-facing outputs of wxyz_sequencer.
// slave = the sequencer itself, master = whoever drives start/stop/pause.
interface wxyz_sequencer_if;
    logic       start;
    logic       stop;
    logic       pause;
    logic       w;
    logic       x;
    logic       y;
    logic       z;
    logic [3:0] seq_idx;
    logic       valid;
    logic       busy;
    logic       done;
    logic       wrap;

    modport slave (
        input  start, stop, pause,
        output w, x, y, z, seq_idx, valid, busy, done, wrap
    );

    modport master (
        output start, stop, pause,
        input  w, x, y, z, seq_idx, valid, busy, done, wrap
    );
endinterface

// File: rtl/wxyz_sequencer.sv
// Sweeps the 16 converter input codes, holding each for DWELL cycles, with pause/stop/loop.
// Define WXYZ_SEQ_GRAY_EN to present codes in reflected Gray order instead of binary.
//
//   state  | meaning
//   IDLE   | no sweep, outputs zero, waiting for start
//   RUN    | presenting code(seq_idx), dwell counter decrementing
//   HOLD   | paused; code, index and counter frozen
//   DONE   | one-shot sweep complete, done high until start or stop
module wxyz_sequencer #(
    parameter int unsigned DWELL = 5,
    parameter bit          LOOP  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    wxyz_sequencer_if.slave   bus
);

    localparam logic [15:0] RELOAD = 16'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wrap_q, wrap_d;
    logic        active_d;

    function automatic logic [3:0] to_code(input logic [3:0] idx);
`ifdef WXYZ_SEQ_GRAY_EN
        return idx ^ {1'b0, idx[3:1]};
`else
        return idx;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;

        if (bus.stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                        idx_d   = '0;
                        cnt_d   = RELOAD;
                    end
                end
                S_RUN, S_HOLD: begin
                    if (bus.pause) begin
                        state_d = S_HOLD;
                    end else begin
                        // Leaving HOLD counts as a normal dwell cycle, so HOLD cycles are the only ones excluded.
                        state_d = S_RUN;
                        if (cnt_q != 16'd0) begin
                            cnt_d = cnt_q - 16'd1;
                        end else if (idx_q != 4'hF) begin
                            idx_d = idx_q + 4'd1;
                            cnt_d = RELOAD;
                        end else if (LOOP) begin
                            idx_d  = '0;
                            cnt_d  = RELOAD;
                            wrap_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                            idx_d   = '0;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        active_d = (state_d == S_RUN) || (state_d == S_HOLD);
        code_d   = active_d ? to_code(idx_d) : 4'd0;
        valid_d  = active_d;
        busy_d   = active_d;
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.w       = code_q[3];
    assign bus.x       = code_q[2];
    assign bus.y       = code_q[1];
    assign bus.z       = code_q[0];
    assign bus.seq_idx = idx_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: doc/wxyz_sequencer.md
# wxyz_sequencer

Synchronous stimulus sequencer that drives the 4-bit input word (w, x, y, z) of the code-converter stage directly downstream of it. On a start request it steps through all 16 input codes, holding each for a programmable number of clock cycles, then stops or loops. It replaces hand-written per-vector delays with a repeatable on-chip sweep. It flags when the converter inputs are valid, paused, or finished.

## Interface
- DWELL, 5: cycles each code is held; legal range 1..65535 (5 cycles at 10 ns = 50 ns per vector).
- LOOP, 0: 0 = stop after code 15; 1 = wrap to code 0 and continue.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE and DONE.
- stop  in  1  abort the sweep and return to IDLE; highest priority.
- pause  in  1  level; freezes the sweep while high.
- w  out  1  code bit 3 (MSB) to the converter.
- x  out  1  code bit 2.
- y  out  1  code bit 1.
- z  out  1  code bit 0 (LSB).
- seq_idx  out  4  sweep position 0..15, always binary.
- valid  out  1  high while w..z carry a sweep code (RUN or HOLD).
- busy  out  1  high in RUN or HOLD.
- done  out  1  level; high in DONE.
- wrap  out  1  one-cycle pulse when LOOP=1 and the index wraps 15->0.

## Operation
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- IDLE -> RUN on start. seq_idx=0 and the dwell counter is loaded with DWELL-1.
- RUN: the dwell counter decrements every cycle. At 0 it does the following:
  - if seq_idx<15: increment seq_idx and reload the counter;
  - if seq_idx=15 and LOOP=0: go to DONE;
  - if seq_idx=15 and LOOP=1: set seq_idx=0, reload the counter, pulse wrap.
- RUN -> HOLD while pause=1. The counter and seq_idx freeze. HOLD -> RUN when pause=0, and counting resumes from the frozen value.
- DONE: w..z=0, seq_idx=0, valid=0, done=1. start re-enters RUN from code 0.
- stop in any state forces IDLE on the next edge: w..z=0, seq_idx=0, valid=0, busy=0, done=0.
- Priority on simultaneous inputs is stop > pause > start. start in RUN or HOLD is ignored. pause in IDLE or DONE is ignored.
- start together with pause in IDLE: enter RUN, then go to HOLD on the following edge if pause is still high. Code 0 is presented during that cycle.
- {w,x,y,z} = code(seq_idx); see Configuration.
- Counter is 16 bits. DWELL=1 changes the code every cycle.

## Timing
- Reset values: w=x=y=z=0, seq_idx=0, valid=0, busy=0, done=0, wrap=0, state=IDLE.
- start sampled high at edge N: valid=1 and code 0 appear after edge N.
- Each code is stable for exactly DWELL cycles, excluding cycles spent in HOLD.
- One-shot sweep length is 16*DWELL cycles. done rises on the edge after the last cycle of code 15.
- wrap is high for exactly the first cycle of the new code 0.
- Asserting reset mid-sweep immediately (asynchronously) forces all reset values.
- Reset deassertion takes effect at the next rising clk edge.

## Configuration
- WXYZ_SEQ_GRAY_EN defined: {w,x,y,z} = seq_idx ^ (seq_idx>>1), a reflected Gray order, so only one converter input changes per step.
- Not defined: {w,x,y,z} = seq_idx, plain binary order 0000..1111.
- seq_idx, timing and the state machine are identical in both builds.

## Test plan
- Reset, DWELL=5, LOOP=0, binary build, start pulse:
  - w..z steps 0000..1111, each held exactly 5 cycles;
  - done rises 80 cycles after the first valid cycle;
  - outputs return to 0.
- pause high for 7 cycles during code 0110 (third cycle of its dwell): code held 5+7 cycles total, busy=1, valid=1, following codes unaffected.
- stop asserted during code 1010 together with start and pause: IDLE next cycle, all outputs 0, and a later start restarts at 0000.
- LOOP=1, DWELL=1: codes change every cycle; wrap pulses once every 16 cycles, coincident with seq_idx=0; done stays 0.
- WXYZ_SEQ_GRAY_EN build, DWELL=2: code sequence 0000,0001,0011,0010,0110,... and exactly one bit changes per transition.
- rst_n pulled low at code 1100 of a sweep: outputs reach reset values without a clock edge; the sweep restarts only on a new start.
